freq_meter_multi: RTL and testbench
===================================

Name: freq_meter_multi

Overview:
Multi-channel frequency measurement core that counts rising edges on up to NUM_CH asynchronous input clocks over a programmable gate window derived from sys_clk. It generalises the single-channel pulse counter and counter control pair. It adds a parametrised channel count and counter width, single-shot and continuous modes, a saturating overflow flag, and a valid/ready result stream. The result stream feeds the hex-to-decimal and display path one channel at a time.

Parameters:
NUM_CH, 4, number of measured inputs; must be >= 2.
CNT_W, 24, edge counter and result width.
GATE_W, 8, width of the gate length input.
GATE_UNIT_CYC, 50000, sys_clk cycles per gate unit (1 ms at 50 MHz).
CH_W, $clog2(NUM_CH), width of the channel index (derived).

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  asynchronous active-low reset
meas_clk  in  NUM_CH  asynchronous inputs to measure, one bit per channel
gate_len  in  GATE_W  gate length in units; 0 is treated as 1
mode  in  1  0 = single-shot, 1 = continuous
start  in  1  one-cycle pulse that begins measurement
stop  in  1  one-cycle pulse that aborts and returns to IDLE
busy  out  1  high in any state other than IDLE
res_valid  out  1  result payload valid
res_ready  in  1  downstream accepts the result
res_ch  out  CH_W  channel index of the current result
res_count  out  CNT_W  rising-edge count for res_ch
res_ovf  out  1  count saturated for res_ch
res_gate  out  GATE_W  effective gate length used for this result set

Behaviour:
- Reset: sys_rst is asynchronous, active-low; clock is sys_clk. All of the following clear to 0: outputs, state (IDLE), counters, prescaler, synchronisers.
- Per-channel input path: 2-FF synchroniser, then a registered rising-edge detect, giving one sys_clk pulse per edge. Edge-to-count latency is 3 cycles. Inputs are valid below sys_clk/2.
- State machine IDLE -> ARM -> GATE -> UNLOAD:
  - IDLE: a start pulse moves to ARM.
  - ARM (1 cycle): latch eff_gate = max(gate_len, 1); clear the prescaler, unit counter, edge counters and ovf flags. Edges arriving in ARM are not counted.
  - GATE: lasts exactly eff_gate*GATE_UNIT_CYC cycles. An edge pulse in any GATE cycle, including the last, increments that channel's counter. On the last GATE cycle, the final counts and ovf flags are snapshotted into result registers.
  - UNLOAD: present channels 0..NUM_CH-1 in ascending order.
    - On res_valid && res_ready, advance to the next channel.
    - After the last channel transfers: if mode is 1 and stop has not occurred, go to ARM; otherwise go to IDLE.
    - mode is sampled only at this decision point.
- Timing: start accepted at cycle 0 gives ARM at cycle 1, GATE on cycles 2..G+1 (G = eff_gate*GATE_UNIT_CYC), and first res_valid at cycle G+2.
- Counters are not active outside GATE. Dead time between continuous gates is UNLOAD duration plus 1 cycle.
- Saturation: a counter at all-ones holds its value and sets ovf. It never wraps.
- Handshake: res_valid stays high throughout UNLOAD. res_ch, res_count, res_ovf and res_gate stay stable until accepted. res_valid is never dropped without a transfer, except on stop.
- stop: in any state, go to IDLE on the next cycle and drop res_valid. No partial results are emitted. If start and stop arrive in the same cycle, stop wins.
- start while busy is ignored. gate_len changes take effect only at the next ARM.

Test Plan:
1. Reset: hold sys_rst low with inputs toggling -> busy = 0, res_valid = 0, res_count = 0, res_ch = 0. Assert sys_rst mid-GATE -> everything clears immediately.
2. Basic count: GATE_UNIT_CYC = 10, gate_len = 5, res_ready = 1. ch0 rises every 10 cycles (aligned), ch1 held 0, ch2 rises every 4 cycles, ch3 held 1 -> results ch0 = 5, ch1 = 0, ch2 = 12 or 13, ch3 = 0, all ovf = 0, res_gate = 5, res_ch sequence 0, 1, 2, 3. First res_valid at cycle 52 after the start pulse.
3. Overflow: CNT_W = 4, ch0 at sys_clk/2, gate = 50 cycles -> res_count = 15, res_ovf = 1. Other channels unaffected.
4. Backpressure: res_ready low for 20 cycles in UNLOAD -> res_valid stays 1 and ch0 payload holds. Then toggle res_ready on alternate cycles -> exactly 4 transfers in order, with no duplicates and no skipped channels.
5. Continuous + stop: mode = 1 -> two complete 4-result sets back to back, with the second ARM occurring 1 cycle after the last transfer. A stop pulse during the third GATE -> busy = 0 on the next cycle and no further res_valid.
6. Edge cases:
   - gate_len = 0 -> gate lasts 10 cycles and res_gate = 1.
   - start and stop in the same cycle -> stays IDLE.
   - start pulses during GATE -> ignored, and the count is unchanged.

Source files
------------

// File: rtl/freq_meter_multi.sv
// Multi-channel frequency meter: counts rising edges on NUM_CH asynchronous inputs
// over a programmable sys_clk gate window and streams per-channel results.
module freq_meter_multi #(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned CNT_W         = 24,
    parameter int unsigned GATE_W        = 8,
    parameter int unsigned GATE_UNIT_CYC = 50000,
    parameter int unsigned CH_W          = $clog2(NUM_CH)
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [NUM_CH-1:0] meas_clk,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              mode,
    input  logic              start,
    input  logic              stop,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CH_W-1:0]   res_ch,
    output logic [CNT_W-1:0]  res_count,
    output logic              res_ovf,
    output logic [GATE_W-1:0] res_gate
);

    localparam int unsigned   PRE_W    = (GATE_UNIT_CYC > 1) ? $clog2(GATE_UNIT_CYC) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(GATE_UNIT_CYC - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, ARM, GATE, UNLOAD} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [NUM_CH-1:0]   sync1;
    logic [NUM_CH-1:0]   sync2;
    logic [NUM_CH-1:0]   sync3;
    logic [NUM_CH-1:0]   rise;
    logic [PRE_W-1:0]    pre_cnt;
    logic [GATE_W-1:0]   unit_cnt;
    logic [GATE_W-1:0]   gate_eff;
    logic [CNT_W-1:0]    cnt      [NUM_CH];
    logic [CNT_W-1:0]    cnt_nxt  [NUM_CH];
    logic [CNT_W-1:0]    snap_cnt [NUM_CH];
    logic [NUM_CH-1:0]   ovf;
    logic [NUM_CH-1:0]   ovf_nxt;
    logic [NUM_CH-1:0]   snap_ovf;
    logic                gate_last;
    logic                xfer;
    logic [CH_W-1:0]     ch_nxt;

    // Two-flop synchroniser plus a third flop for rising-edge detection.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= meas_clk;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise      = sync2 & ~sync3;
    assign gate_last = (state == GATE) && (pre_cnt == PRE_LAST)
                       && (unit_cnt == gate_eff - GATE_W'(1));
    assign xfer      = (state == UNLOAD) && res_valid && res_ready;
    assign ch_nxt    = res_ch + CH_W'(1);

    // Saturating per-channel increment; an edge at all-ones flags overflow.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_nxt[i] = cnt[i];
            ovf_nxt[i] = ovf[i];
            if (rise[i]) begin
                if (&cnt[i]) begin
                    ovf_nxt[i] = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ARM;
            ARM:     state_nxt = GATE;
            GATE:    if (gate_last) state_nxt = UNLOAD;
            UNLOAD:  if (xfer && (res_ch == CH_LAST)) state_nxt = mode ? ARM : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (stop) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != IDLE);
            res_valid <= (state_nxt == UNLOAD);
        end
    end

    // Gate timebase: prescaler of GATE_UNIT_CYC cycles, unit counter up to gate_eff.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            pre_cnt  <= '0;
            unit_cnt <= '0;
            gate_eff <= '0;
        end else if (state == ARM) begin
            pre_cnt  <= '0;
            unit_cnt <= '0;
            gate_eff <= (gate_len == '0) ? GATE_W'(1) : gate_len;
        end else if (state == GATE) begin
            if (pre_cnt == PRE_LAST) begin
                pre_cnt  <= '0;
                unit_cnt <= unit_cnt + GATE_W'(1);
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
            ovf <= '0;
        end else if (state == ARM) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
            ovf <= '0;
        end else if (state == GATE) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            ovf <= ovf_nxt;
        end
    end

    // Snapshot includes the final gate cycle's edges; channel 0 is presented directly.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                snap_cnt[i] <= '0;
            end
            snap_ovf  <= '0;
            res_ch    <= '0;
            res_count <= '0;
            res_ovf   <= 1'b0;
            res_gate  <= '0;
        end else if (gate_last) begin
            for (int i = 0; i < NUM_CH; i++) begin
                snap_cnt[i] <= cnt_nxt[i];
            end
            snap_ovf  <= ovf_nxt;
            res_ch    <= '0;
            res_count <= cnt_nxt[0];
            res_ovf   <= ovf_nxt[0];
            res_gate  <= gate_eff;
        end else if (xfer && (res_ch != CH_LAST)) begin
            res_ch    <= ch_nxt;
            res_count <= snap_cnt[ch_nxt];
            res_ovf   <= snap_ovf[ch_nxt];
        end
    end

endmodule

// File: tb/tb_freq_meter_multi.sv
// Directed bench for freq_meter_multi: synchronous stimulus patterns with
// hand-computed edge counts, latencies and handshake behaviour.
module tb_freq_meter_multi;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned GATE_W = 8;
    localparam int unsigned UNIT   = 10;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b0;
    logic [NUM_CH-1:0] meas_clk = '0;
    logic [GATE_W-1:0] gate_len = 8'd5;
    logic              mode = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              busy;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic [1:0]        res_ch;
    logic [CNT_W-1:0]  res_count;
    logic              res_ovf;
    logic [GATE_W-1:0] res_gate;

    int checks = 0;
    int failures = 0;

    int                ch_period [NUM_CH];
    logic [NUM_CH-1:0] ch_level = 4'b1000;
    int                tcnt = 0;

    int got_ch [8];
    int got_cnt [8];
    int got_ovf [8];
    int got_gate [8];
    int nx;
    int n;
    int held;
    int seen;
    int c0;

    freq_meter_multi #(
        .NUM_CH        (NUM_CH),
        .CNT_W         (CNT_W),
        .GATE_W        (GATE_W),
        .GATE_UNIT_CYC (UNIT)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .meas_clk  (meas_clk),
        .gate_len  (gate_len),
        .mode      (mode),
        .start     (start),
        .stop      (stop),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_ch    (res_ch),
        .res_count (res_count),
        .res_ovf   (res_ovf),
        .res_gate  (res_gate)
    );

    always #5 sys_clk = ~sys_clk;

    // Periodic inputs (period 0 = hold ch_level), updated away from the active edge.
    always @(negedge sys_clk) begin
        tcnt = tcnt + 1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_period[i] == 0) meas_clk[i] = ch_level[i];
            else meas_clk[i] = ((tcnt % ch_period[i]) < (ch_period[i] / 2));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t reached, expected bench completion", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_pulse();
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    // Posedges from the start-sampling edge until res_valid is observed.
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!res_valid && cyc < 200) begin
            @(negedge sys_clk);
            cyc++;
        end
    endtask

    task automatic collect(input int want, input int limit);
        nx = 0;
        for (int k = 0; k < limit && nx < want; k++) begin
            if (res_valid && res_ready) begin
                got_ch[nx]   = int'(res_ch);
                got_cnt[nx]  = int'(res_count);
                got_ovf[nx]  = int'(res_ovf);
                got_gate[nx] = int'(res_gate);
                nx++;
            end
            @(negedge sys_clk);
        end
    endtask

    task automatic check_set(input string tag, input int exp0);
        check({tag, "_nx"}, nx, 4);
        for (int i = 0; i < 4; i++) check({tag, "_ch"}, got_ch[i], i);
        check({tag, "_cnt0"}, got_cnt[0], exp0);
        check({tag, "_cnt1"}, got_cnt[1], 0);
        check({tag, "_cnt3"}, got_cnt[3], 0);
    endtask

    initial begin
        ch_period[0] = 10;
        ch_period[1] = 0;
        ch_period[2] = 4;
        ch_period[3] = 0;

        // Reset held with inputs toggling.
        repeat (6) @(negedge sys_clk);
        check("rst_busy", busy, 0);
        check("rst_valid", res_valid, 0);
        check("rst_count", res_count, 0);
        check("rst_ch", res_ch, 0);
        sys_rst = 1'b1;
        repeat (4) @(negedge sys_clk);

        // Basic count, gate 5 units = 50 cycles.
        start_pulse();
        wait_valid(n);
        check("basic_lat", n, 52);
        collect(4, 20);
        check_set("basic", 5);
        check("basic_cnt2", int'(got_cnt[2] == 12 || got_cnt[2] == 13), 1);
        check("basic_ovf", got_ovf[0] + got_ovf[1] + got_ovf[2] + got_ovf[3], 0);
        check("basic_gate", got_gate[0], 5);
        check("basic_idle", busy, 0);

        // Backpressure: hold 20 cycles, then alternate ready.
        res_ready = 1'b0;
        start_pulse();
        wait_valid(n);
        c0 = int'(res_count);
        check("bp_c0", c0, 5);
        held = 0;
        repeat (20) begin
            @(negedge sys_clk);
            if (res_valid && res_ch == 2'd0 && int'(res_count) == c0) held++;
        end
        check("bp_hold", held, 20);
        nx = 0;
        for (int k = 0; k < 40 && nx < 4; k++) begin
            res_ready = (k % 2 == 1);
            if (res_valid && res_ready) begin
                got_ch[nx]  = int'(res_ch);
                got_cnt[nx] = int'(res_count);
                nx++;
            end
            @(negedge sys_clk);
        end
        res_ready = 1'b1;
        check_set("bp", 5);
        check("bp_valid_after", res_valid, 0);

        // Overflow: ch0 at sys_clk/2 gives 25 edges against a 4-bit counter.
        ch_period[0] = 2;
        repeat (6) @(negedge sys_clk);
        start_pulse();
        wait_valid(n);
        collect(4, 20);
        check_set("ovf", 15);
        check("ovf_flag0", got_ovf[0], 1);
        check("ovf_cnt2", int'(got_cnt[2] == 12 || got_cnt[2] == 13), 1);
        check("ovf_flag_oth", got_ovf[1] + got_ovf[2] + got_ovf[3], 0);
        ch_period[0] = 10;
        repeat (6) @(negedge sys_clk);

        // Continuous mode, then stop during the third gate.
        mode = 1'b1;
        start_pulse();
        wait_valid(n);
        check("cont1_lat", n, 52);
        collect(4, 20);
        check_set("cont1", 5);
        check("cont_arm_busy", busy, 1);
        check("cont_arm_valid", res_valid, 0);
        wait_valid(n);
        check("cont2_lat", n, 52);
        collect(4, 20);
        check_set("cont2", 5);
        repeat (20) @(negedge sys_clk);
        check("cont3_busy", busy, 1);
        stop = 1'b1;
        @(negedge sys_clk);
        stop = 1'b0;
        check("stop_busy", busy, 0);
        seen = 0;
        repeat (80) begin
            @(negedge sys_clk);
            if (res_valid || busy) seen++;
        end
        check("stop_quiet", seen, 0);
        mode = 1'b0;

        // gate_len 0 behaves as 1 unit.
        gate_len = 8'd0;
        start_pulse();
        wait_valid(n);
        check("g0_lat", n, 12);
        collect(4, 20);
        check("g0_gate", got_gate[0], 1);
        check("g0_cnt0", got_cnt[0], 1);
        gate_len = 8'd5;

        // start and stop together: stop wins.
        @(negedge sys_clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        stop  = 1'b0;
        check("ss_busy", busy, 0);
        seen = 0;
        repeat (10) begin
            @(negedge sys_clk);
            if (res_valid || busy) seen++;
        end
        check("ss_quiet", seen, 0);

        // start pulses during GATE are ignored.
        start_pulse();
        n = 1;
        while (!res_valid && n < 200) begin
            start = (n == 10 || n == 30);
            @(negedge sys_clk);
            n++;
        end
        start = 1'b0;
        check("sg_lat", n, 52);
        collect(4, 20);
        check_set("sg", 5);

        // Asynchronous reset mid-GATE.
        start_pulse();
        repeat (20) @(negedge sys_clk);
        check("mr_busy_pre", busy, 1);
        sys_rst = 1'b0;
        #1;
        check("mr_busy", busy, 0);
        check("mr_valid", res_valid, 0);
        check("mr_count", res_count, 0);
        check("mr_ch", res_ch, 0);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (60) @(negedge sys_clk);
        check("mr_quiet", int'(res_valid || busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
